// File: rtl/reg_file_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package reg_file_arb_pkg;

    // Register file geometry
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        CAPT
    } state_e;

    // Owner encoding; also the value of the round-robin "last granted" pointer
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The grant is combinational and one-hot.
// The last-grant pointer advances whenever a grant is issued, because a grant
// is only ever given to a valid requester, so every grant is an accept.
module rr_arbiter_2
    import reg_file_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req_a,
    input  logic       req_b,
    output logic [1:0] grant
);

    logic last_b_q;

    // Grant selection: a lone requester wins; on a tie the one not last granted wins
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req_a && req_b) begin
                grant = (last_b_q == OWN_B) ? 2'b01 : 2'b10;
            end else if (req_a) begin
                grant = 2'b01;
            end else if (req_b) begin
                grant = 2'b10;
            end
        end
    end

    // Pointer: reset to "last granted B" so A wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b_q <= OWN_B;
        end else if (grant != 2'b00) begin
            last_b_q <= grant[1] ? OWN_B : OWN_A;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares the single read/write port of an 8 x N register file between two
// requesters. Commands are accepted one at a time in IDLE, issued in CMD, and
// reads are captured in CAPT and returned to the owner as a one-cycle pulse.
module reg_file_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [N-1:0]      a_wdata,
    output logic              a_ready,
    output logic              a_rsp_valid,
    output logic [N-1:0]      a_rsp_rdata,

    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [N-1:0]      b_wdata,
    output logic              b_ready,
    output logic              b_rsp_valid,
    output logic [N-1:0]      b_rsp_rdata,

    output logic              rf_read_enable,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [N-1:0]      rf_write_data,
    input  logic [N-1:0]      rf_read_data
);

    state_e            state_q;
    logic              owner_q;
    logic              we_q;

    logic              arb_en;
    logic [1:0]        grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [N-1:0]      sel_wdata;

    // Ready is gated by reset too, so it is low while rst is held
    assign arb_en = rst && (state_q == IDLE);

    rr_arbiter_2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req_a (a_valid),
        .req_b (b_valid),
        .grant (grant)
    );

    assign a_ready = grant[0];
    assign b_ready = grant[1];

    // Command mux: pick the granted requester's fields
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant[1]) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Sequencer with registered outputs. The rf address/data registers double
    // as the latched command, so requester inputs are free after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_A;
            we_q            <= 1'b0;
            rf_read_enable  <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_read_addr    <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            a_rsp_valid     <= 1'b0;
            b_rsp_valid     <= 1'b0;
            a_rsp_rdata     <= '0;
            b_rsp_rdata     <= '0;
        end else begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner_q <= grant[1] ? OWN_B : OWN_A;
                        we_q    <= sel_we;
                        if (sel_we) begin
                            rf_write_enable <= 1'b1;
                            rf_write_addr   <= sel_addr;
                            rf_write_data   <= sel_wdata;
                        end else begin
                            rf_read_enable <= 1'b1;
                            rf_read_addr   <= sel_addr;
                        end
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    rf_write_enable <= 1'b0;
                    rf_read_enable  <= 1'b0;
                    state_q         <= we_q ? IDLE : WAIT;
                end
                WAIT: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    if (owner_q == OWN_B) begin
                        b_rsp_valid <= 1'b1;
                        b_rsp_rdata <= rf_read_data;
                    end else begin
                        a_rsp_valid <= 1'b1;
                        a_rsp_rdata <= rf_read_data;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed vector table, contention and reset
// sequences, and randomized traffic, all checked against a transaction-level
// reference model plus a behavioural register file.
module tb_reg_file_arbiter;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [2:0]    a_addr = '0, b_addr = '0;
    logic [N-1:0]  a_wdata = '0, b_wdata = '0;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [N-1:0]  a_rsp_rdata, b_rsp_rdata;
    logic          rf_read_enable, rf_write_enable;
    logic [2:0]    rf_read_addr, rf_write_addr;
    logic [N-1:0]  rf_write_data;
    logic [N-1:0]  rf_read_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_arbiter #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .a_valid         (a_valid),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .a_ready         (a_ready),
        .a_rsp_valid     (a_rsp_valid),
        .a_rsp_rdata     (a_rsp_rdata),
        .b_valid         (b_valid),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .b_ready         (b_ready),
        .b_rsp_valid     (b_rsp_valid),
        .b_rsp_rdata     (b_rsp_rdata),
        .rf_read_enable  (rf_read_enable),
        .rf_write_enable (rf_write_enable),
        .rf_read_addr    (rf_read_addr),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_read_data    (rf_read_data)
    );

    // Behavioural register file: synchronous write, registered read
    logic [N-1:0] rf_mem [8] = '{default: '0};
    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
        if (rf_read_enable)  rf_read_data <= rf_mem[rf_read_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model (transaction level) ----------------
    // Commands are serialized: a write occupies 1 cycle after accept, a read
    // 3 cycles, with the response visible 3 cycles after the accept edge.
    int           cyc      = 0;
    int           busy     = 0;
    logic         last_b   = 1'b1;
    logic [N-1:0] mem_m [8] = '{default: '0};
    logic         acc_live = 1'b0, acc_we = 1'b0, acc_owner = 1'b0;
    int           acc_cyc  = -10;
    logic [2:0]   acc_addr = '0;
    logic [N-1:0] acc_data = '0;
    logic         rsp_live = 1'b0, rsp_owner = 1'b0;
    int           rsp_cyc  = -10;
    logic [N-1:0] rsp_data = '0, exp_a_rd = '0, exp_b_rd = '0;

    function automatic logic [1:0] model_grant();
        if (!rst || busy != 0) return 2'b00;
        if (a_valid && b_valid) return last_b ? 2'b01 : 2'b10;
        if (a_valid) return 2'b01;
        if (b_valid) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        logic [1:0] g;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                busy = 0; last_b = 1'b1; acc_live = 1'b0; rsp_live = 1'b0;
                exp_a_rd = '0; exp_b_rd = '0;
            end else begin
                cyc++;
                if (acc_live && acc_we && cyc == acc_cyc + 1) mem_m[acc_addr] = acc_data;
                if (rsp_live && cyc == rsp_cyc) begin
                    if (rsp_owner) exp_b_rd = rsp_data;
                    else           exp_a_rd = rsp_data;
                end
                if (rsp_live && cyc == rsp_cyc + 1) rsp_live = 1'b0;
                if (busy > 0) begin
                    busy--;
                end else begin
                    g = model_grant();
                    if (g != 2'b00) begin
                        acc_live  = 1'b1;
                        acc_cyc   = cyc;
                        acc_owner = g[1];
                        acc_we    = g[1] ? b_we    : a_we;
                        acc_addr  = g[1] ? b_addr  : a_addr;
                        acc_data  = g[1] ? b_wdata : a_wdata;
                        last_b    = g[1];
                        busy      = acc_we ? 1 : 3;
                        if (!acc_we) begin
                            rsp_live  = 1'b1;
                            rsp_cyc   = cyc + 3;
                            rsp_owner = acc_owner;
                            rsp_data  = mem_m[acc_addr];
                        end
                    end
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    initial begin
        logic [1:0] g;
        logic       ew, er;
        forever begin
            @(negedge clk);
            if (rst) begin
                g  = model_grant();
                ew = acc_live && acc_we && (cyc == acc_cyc);
                er = acc_live && !acc_we && (cyc == acc_cyc);
                check("a_ready", a_ready, g[0]);
                check("b_ready", b_ready, g[1]);
                check("a_rsp_valid", a_rsp_valid, rsp_live && cyc == rsp_cyc && !rsp_owner);
                check("b_rsp_valid", b_rsp_valid, rsp_live && cyc == rsp_cyc && rsp_owner);
                check("a_rsp_rdata", a_rsp_rdata, exp_a_rd);
                check("b_rsp_rdata", b_rsp_rdata, exp_b_rd);
                check("rf_write_enable", rf_write_enable, ew);
                check("rf_read_enable", rf_read_enable, er);
                check("enables_exclusive", rf_read_enable & rf_write_enable, 1'b0);
                if (ew) begin
                    check("rf_write_addr", rf_write_addr, acc_addr);
                    check("rf_write_data", rf_write_data, acc_data);
                end
                if (er) check("rf_read_addr", rf_read_addr, acc_addr);
            end
        end
    end

    // ---------------- Directed single command ----------------
    // Entered and left at #1 after a rising edge.
    task automatic do_cmd(input logic is_b, input logic we, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input string tag);
        logic seen;
        int   lat, ren, wen, own_n, oth_n;
        logic [31:0] rd;
        if (is_b) begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else      begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (is_b ? b_ready : a_ready) begin seen = 1'b1; break; end
        end
        check({tag, "_accept"}, seen, 1'b1);
        @(posedge clk); #1;
        // Scramble inputs after accept; the command must already be latched
        a_valid = 0; b_valid = 0;
        a_we = ~we; b_we = ~we; a_addr = ~addr; b_addr = ~addr;
        a_wdata = ~wdata; b_wdata = ~wdata;
        lat = -1; ren = 0; wen = 0; own_n = 0; oth_n = 0; rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ren += int'(rf_read_enable);
            wen += int'(rf_write_enable);
            if (is_b ? a_rsp_valid : b_rsp_valid) oth_n++;
            if (is_b ? b_rsp_valid : a_rsp_valid) begin
                own_n++;
                if (lat < 0) begin lat = k; rd = is_b ? b_rsp_rdata : a_rsp_rdata; end
            end
        end
        check({tag, "_other_rsp"}, oth_n, 0);
        if (we) begin
            check({tag, "_wen_cycles"}, wen, 1);
            check({tag, "_no_rsp"}, own_n, 0);
        end else begin
            check({tag, "_ren_cycles"}, ren, 1);
            check({tag, "_rsp_pulses"}, own_n, 1);
            check({tag, "_latency"}, lat, 3);
            check({tag, "_rdata"}, rd, exp_rd);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        is_b;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int   grants, alt_bad, na, nb, ra, rb, nrsp;
        logic prev;
        logic got;

        tbl[0]  = '{1'b0, 1'b1, 3'd3, 32'h0000_00A5, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 3'd3, 32'h0,         32'h0000_00A5};
        tbl[2]  = '{1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'd5, 32'h0,         32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b1, 3'd7, 32'h5A5A_5A5A, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 3'd7, 32'h0000_0000, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 32'h0,         32'hFFFF_FFFF};
        tbl[8]  = '{1'b1, 1'b0, 3'd7, 32'h0,         32'h0000_0000};
        tbl[9]  = '{1'b1, 1'b0, 3'd3, 32'h0,         32'h0000_00A5};
        tbl[10] = '{1'b0, 1'b0, 3'd5, 32'h0,         32'hDEAD_BEEF};
        tbl[11] = '{1'b0, 1'b1, 3'd1, 32'h0000_0011, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 3'd2, 32'h0000_0022, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h0,         32'h0000_0011};

        // Reset state
        #13;
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_rf_enables", {rf_read_enable, rf_write_enable}, 2'b00);
        check("rst_rsp", {a_rsp_valid, b_rsp_valid}, 2'b00);
        check("rst_rf_write_data", rf_write_data, 32'h0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            do_cmd(tbl[i].is_b, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
                   $sformatf("vec%0d", i));
        end

        // Continuous contention: 4 reads each, grants must alternate
        a_valid = 1; a_we = 0; a_addr = 3'd1;
        b_valid = 1; b_we = 0; b_addr = 3'd2;
        grants = 0; alt_bad = 0; na = 0; nb = 0; ra = 0; rb = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                if (grants > 0 && b_ready == prev) alt_bad++;
                prev = b_ready;
                grants++;
                if (b_ready) nb++; else na++;
            end
            if (a_rsp_valid) begin ra++; check("cont_a_rdata", a_rsp_rdata, 32'h11); end
            if (b_rsp_valid) begin rb++; check("cont_b_rdata", b_rsp_rdata, 32'h22); end
            @(posedge clk); #1;
            if (grants == 8) begin a_valid = 0; b_valid = 0; end
        end
        check("cont_grants", grants, 8);
        check("cont_alternate", alt_bad, 0);
        check("cont_a_grants", na, 4);
        check("cont_b_grants", nb, 4);
        check("cont_a_rsps", ra, 4);
        check("cont_b_rsps", rb, 4);

        // Reset during WAIT of a read
        a_valid = 1; a_we = 0; a_addr = 3'd2;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_ready) begin got = 1'b1; break; end
        end
        check("rstmid_accept", got, 1'b1);
        @(posedge clk); #1 a_valid = 0;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("rstmid_ready", {a_ready, b_ready}, 2'b00);
        check("rstmid_rsp_valid", {a_rsp_valid, b_rsp_valid}, 2'b00);
        check("rstmid_a_rdata", a_rsp_rdata, 32'h0);
        check("rstmid_b_rdata", b_rsp_rdata, 32'h0);
        check("rstmid_enables", {rf_read_enable, rf_write_enable}, 2'b00);
        check("rstmid_addrs", {rf_read_addr, rf_write_addr}, 6'd0);
        check("rstmid_wdata", rf_write_data, 32'h0);
        @(negedge clk); #1 rst = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nrsp += int'(a_rsp_valid) + int'(b_rsp_valid);
        end
        check("rstmid_no_rsp", nrsp, 0);
        @(posedge clk); #1;
        a_valid = 1; a_we = 0; a_addr = 3'd1;
        b_valid = 1; b_we = 0; b_addr = 3'd2;
        @(negedge clk);
        check("post_rst_tie", {b_ready, a_ready}, 2'b01);
        @(posedge clk); #1 a_valid = 0; b_valid = 0;
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_we    = 1'($urandom_range(0, 1));
            a_addr  = 3'($urandom_range(0, 7));
            a_wdata = $urandom;
            b_valid = ($urandom_range(0, 2) != 0);
            b_we    = 1'($urandom_range(0, 1));
            b_addr  = 3'($urandom_range(0, 7));
            b_wdata = $urandom;
            @(posedge clk); #1;
        end
        a_valid = 0; b_valid = 0;
        repeat (6) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched",
                 n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
